// File: rtl/fifo_priority.sv
// Two-class buffered queue: high-priority words (MSB=1) overtake queued low-priority
// words, FIFO order is kept within each class, and a stalled head word is held stable.
module fifo_priority #(
    parameter int DW    = 33,
    parameter int DEPTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic          vld_i,
    output logic          rdy_o,
    output logic [DW-1:0] data_out,
    output logic          vld_o,
    input  logic          rdy_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0] r_mem_h [DEPTH];
    logic [DW-1:0] r_mem_l [DEPTH];
    logic [PW-1:0] r_wr_ptr_h, r_rd_ptr_h, r_wr_ptr_l, r_rd_ptr_l;
    logic [CW-1:0] r_cnt_h, r_cnt_l;
    logic          r_lock, r_lock_h;

    logic w_empty_h, w_empty_l, w_full_h, w_full_l;
    logic w_sel_h, w_push_h, w_push_l, w_pop_h, w_pop_l;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic push, input logic pop);
        logic [CW-1:0] nxt;
        case ({push, pop})
            2'b10:   nxt = cnt + CW'(1);
            2'b01:   nxt = cnt - CW'(1);
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    // Queue status, write acceptance, read selection and head presentation.
    always_comb begin
        w_empty_h = (r_cnt_h == {CW{1'b0}});
        w_empty_l = (r_cnt_l == {CW{1'b0}});
        w_full_h  = (r_cnt_h == CNT_FULL);
        w_full_l  = (r_cnt_l == CNT_FULL);

        rdy_o    = data_in[DW-1] ? !w_full_h : !w_full_l;
        w_push_h = vld_i && rdy_o && data_in[DW-1];
        w_push_l = vld_i && rdy_o && !data_in[DW-1];

        // A stalled selection is frozen so a late high word cannot swap the presented word.
        w_sel_h = r_lock ? r_lock_h : !w_empty_h;
        vld_o   = w_sel_h ? !w_empty_h : !w_empty_l;

        if (!vld_o) begin
            data_out = {DW{1'b0}};
        end else if (w_sel_h) begin
            data_out = r_mem_h[r_rd_ptr_h];
        end else begin
            data_out = r_mem_l[r_rd_ptr_l];
        end

        w_pop_h = vld_o && rdy_i && w_sel_h;
        w_pop_l = vld_o && rdy_i && !w_sel_h;
    end

    // Storage arrays; stale contents after reset are unreachable because pointers clear.
    always_ff @(posedge clk) begin
        if (w_push_h) begin
            r_mem_h[r_wr_ptr_h] <= data_in;
        end
        if (w_push_l) begin
            r_mem_l[r_wr_ptr_l] <= data_in;
        end
    end

    // Pointers, occupancy counts and the stall lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_h <= {PW{1'b0}};
            r_rd_ptr_h <= {PW{1'b0}};
            r_wr_ptr_l <= {PW{1'b0}};
            r_rd_ptr_l <= {PW{1'b0}};
            r_cnt_h    <= {CW{1'b0}};
            r_cnt_l    <= {CW{1'b0}};
            r_lock     <= 1'b0;
            r_lock_h   <= 1'b0;
        end else begin
            if (w_push_h) begin
                r_wr_ptr_h <= ptr_inc(r_wr_ptr_h);
            end
            if (w_push_l) begin
                r_wr_ptr_l <= ptr_inc(r_wr_ptr_l);
            end
            if (w_pop_h) begin
                r_rd_ptr_h <= ptr_inc(r_rd_ptr_h);
            end
            if (w_pop_l) begin
                r_rd_ptr_l <= ptr_inc(r_rd_ptr_l);
            end
            r_cnt_h  <= cnt_next(r_cnt_h, w_push_h, w_pop_h);
            r_cnt_l  <= cnt_next(r_cnt_l, w_push_l, w_pop_l);
            r_lock   <= vld_o && !rdy_i;
            r_lock_h <= w_sel_h;
        end
    end

endmodule

// File: tb/tb_fifo_priority.sv
// Directed bench for fifo_priority: reset, class ordering, stall lock, full boundary,
// pointer wrap, same-queue push/pop and mid-stream reset.
module tb_fifo_priority;

    localparam int DW    = 33;
    localparam int DEPTH = 5;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          vld_i;
    logic          rdy_o;
    logic [DW-1:0] data_out;
    logic          vld_o;
    logic          rdy_i;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_priority #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .vld_i    (vld_i),
        .rdy_o    (rdy_o),
        .data_out (data_out),
        .vld_o    (vld_o),
        .rdy_i    (rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] w_l(input logic [31:0] p);
        return {1'b0, p};
    endfunction

    function automatic logic [DW-1:0] w_h(input logic [31:0] p);
        return {1'b1, p};
    endfunction

    initial begin
        int sent;
        int got;
        rst = 1'b1; data_in = '0; vld_i = 1'b0; rdy_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset and idle
        chk("rst_vld_o", vld_o, 1'b0);
        chk("rst_data_out", data_out, '0);
        chk("rst_rdy_o_lo", rdy_o, 1'b1);
        data_in = w_h(32'h0); #1;
        chk("rst_rdy_o_hi", rdy_o, 1'b1);
        step();

        // Ordering: L1 is locked by the stall before AA arrives, so AA overtakes only L2
        vld_i = 1'b1; data_in = w_l(32'h1); step();
        chk("ord_first_vis", data_out, w_l(32'h1));
        data_in = w_l(32'h2); step();
        data_in = w_h(32'hAA); step();
        vld_i = 1'b0; rdy_i = 1'b1; #1;
        chk("ord_0", data_out, w_l(32'h1));
        step();
        chk("ord_1", data_out, w_h(32'hAA));
        step();
        chk("ord_2", data_out, w_l(32'h2));
        step();
        chk("ord_empty", vld_o, 1'b0);
        rdy_i = 1'b0;

        // Lock rule
        vld_i = 1'b1; data_in = w_l(32'h10); step();
        chk("lock_vld", vld_o, 1'b1);
        chk("lock_head", data_out, w_l(32'h10));
        data_in = w_h(32'h20); step();
        chk("lock_hold1", data_out, w_l(32'h10));
        vld_i = 1'b0; step();
        chk("lock_hold2", data_out, w_l(32'h10));
        chk("lock_vld2", vld_o, 1'b1);
        rdy_i = 1'b1; step();
        chk("lock_next", data_out, w_h(32'h20));
        step();
        chk("lock_empty", vld_o, 1'b0);
        rdy_i = 1'b0;

        // Full boundary on H
        for (int i = 1; i <= 5; i++) begin
            data_in = w_h(32'h100 + 32'(i)); vld_i = 1'b1; #1;
            chk("full_rdy_before", rdy_o, 1'b1);
            step();
        end
        vld_i = 1'b0; data_in = w_h(32'h106); #1;
        chk("full_rdy_hi", rdy_o, 1'b0);
        data_in = w_l(32'h0); #1;
        chk("full_rdy_lo", rdy_o, 1'b1);
        data_in = w_h(32'h106); vld_i = 1'b1; step();
        vld_i = 1'b0; rdy_i = 1'b1; #1;
        chk("full_head", data_out, w_h(32'h101));
        step();
        rdy_i = 1'b0; #1;
        chk("full_rdy_restored", rdy_o, 1'b1);
        rdy_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("full_drain", data_out, w_h(32'h100 + 32'(i)));
            step();
        end
        chk("full_no_sixth", vld_o, 1'b0);
        rdy_i = 1'b0;

        // Wrap-around on L with interleaved push/pop
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
            vld_i   = (sent < 12);
            data_in = w_l(32'(sent + 1));
            rdy_i   = ((cyc % 3) != 0);
            #1;
            if (vld_o && rdy_i) begin
                chk("wrap_order", data_out, w_l(32'(got + 1)));
                got++;
            end
            if (vld_i && rdy_o) begin
                sent++;
            end
            step();
        end
        vld_i = 1'b0; rdy_i = 1'b0; #1;
        chk("wrap_count", 64'(got), 64'd12);
        chk("wrap_empty", vld_o, 1'b0);

        // Same-queue push and pop at count 3
        vld_i = 1'b1;
        data_in = w_l(32'h31); step();
        data_in = w_l(32'h32); step();
        data_in = w_l(32'h33); step();
        data_in = w_l(32'h34); rdy_i = 1'b1; step();
        chk("same_head", data_out, w_l(32'h32));
        rdy_i = 1'b0;
        data_in = w_l(32'h35); step();
        data_in = w_l(32'h36); #1;
        chk("same_cnt4_rdy", rdy_o, 1'b1);
        step();
        vld_i = 1'b0; #1;
        chk("same_cnt5_full", rdy_o, 1'b0);
        rdy_i = 1'b1; step();
        chk("same_order1", data_out, w_l(32'h33));
        step();
        chk("same_order2", data_out, w_l(32'h34));

        // Reset mid-stream overrides a simultaneous push and pop
        rst = 1'b1; vld_i = 1'b1; data_in = w_l(32'h99); step();
        rst = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; #1;
        chk("mrst_vld", vld_o, 1'b0);
        chk("mrst_data", data_out, '0);
        chk("mrst_rdy", rdy_o, 1'b1);
        step();
        chk("mrst_discarded", vld_o, 1'b0);
        vld_i = 1'b1; data_in = w_l(32'h77); step();
        vld_i = 1'b0; #1;
        chk("mrst_fresh", data_out, w_l(32'h77));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
